// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the fir filter.
//   SAMPLE_W / COEFF_W / FRAC_BITS : sample, coefficient and Q1.15 fraction widths
//   sample_t / coeff_t             : signed 16-bit sample and coefficient types
//   DEFAULT_COEFF                  : 10-tap symmetric low-pass, unity DC gain (sum = 32768)
//   sat16()                        : round half up at FRAC_BITS, saturate to 16 bits
package fir_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int COEFF_W   = 16;
    localparam int FRAC_BITS = 15;
    // Width of the accumulator view taken by sat16; callers sign-extend into it.
    localparam int SAT_IN_W  = 64;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [COEFF_W-1:0]  coeff_t;

    localparam coeff_t DEFAULT_COEFF [10] = '{
        16'sd492,  16'sd1311, 16'sd2785, 16'sd4588, 16'sd7208,
        16'sd7208, 16'sd4588, 16'sd2785, 16'sd1311, 16'sd492
    };

    function automatic sample_t sat16(input logic signed [SAT_IN_W-1:0] acc);
        logic signed [SAT_IN_W-1:0] half_lsb;
        logic signed [SAT_IN_W-1:0] r;
        half_lsb = 64'sd1 <<< (FRAC_BITS - 1);
        r = (acc + half_lsb) >>> FRAC_BITS;
        if (r > 64'sd32767) begin
            return 16'sh7FFF;
        end else if (r < -64'sd32768) begin
            return 16'sh8000;
        end else begin
            return r[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// fir_adder_tree: combinational signed sum of N IN_W-wide terms.
//   terms : N signed products
//   sum   : signed total, SUM_W wide (wide enough that no overflow occurs)
module fir_adder_tree #(
    parameter int N     = 10,
    parameter int IN_W  = 32,
    parameter int SUM_W = IN_W + $clog2(N)
) (
    input  logic signed [IN_W-1:0]  terms [N],
    output logic signed [SUM_W-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = sum + SUM_W'(terms[i]);
        end
    end

endmodule

// File: rtl/fir.sv
// fir: direct-form, fully pipelined FIR filter, 16-bit signed Q1.15 stream.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   in_valid   : in_sample is valid this cycle (sample is shifted in)
//   in_sample  : signed input sample
//   out_valid  : one-cycle pulse, out_sample carries a new result
//   out_sample : rounded, saturated filter output (holds between pulses)
// Stage 1 registers the TAPS products on the accepting edge; stage 2
// registers the rounded/saturated sum on the following edge.
module fir
    import fir_pkg::*;
#(
    parameter int     TAPS     = 10,
    parameter int     MULTBITS = 32,
    parameter coeff_t COEFF [TAPS] = DEFAULT_COEFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    output logic                       out_valid,
    output logic signed [SAMPLE_W-1:0] out_sample
);

    localparam int ACC_W = MULTBITS + $clog2(TAPS);

    // The newest sample feeds tap 0 straight from in_sample, so only
    // TAPS-1 older samples need storing; the oldest delay-line slot would
    // never be read.
    logic signed [SAMPLE_W-1:0] x [TAPS-1];
    logic signed [MULTBITS-1:0] p [TAPS];
    logic                       v1;
    logic signed [ACC_W-1:0]    acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < TAPS - 1; i++) begin
                x[i] <= '0;
            end
            for (int unsigned i = 0; i < TAPS; i++) begin
                p[i] <= '0;
            end
            v1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                x[0] <= in_sample;
                for (int unsigned i = 1; i < TAPS - 1; i++) begin
                    x[i] <= x[i-1];
                end
                p[0] <= MULTBITS'(in_sample) * MULTBITS'(COEFF[0]);
                for (int unsigned i = 1; i < TAPS; i++) begin
                    p[i] <= MULTBITS'(x[i-1]) * MULTBITS'(COEFF[i]);
                end
            end
        end
    end

    fir_adder_tree #(
        .N     (TAPS),
        .IN_W  (MULTBITS),
        .SUM_W (ACC_W)
    ) u_adder_tree (
        .terms (p),
        .sum   (acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                out_sample <= sat16(SAT_IN_W'(acc));
            end
        end
    end

endmodule

// File: tb/tb_fir.sv
// tb_fir: scoreboard bench for fir. Three instances: default coefficients,
// all-32767 coefficients (saturation) and a single 0.5 tap (rounding).
module tb_fir;

    typedef struct {
        logic signed [15:0] val;
        int                 cyc;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               iv    [3];
    logic signed [15:0] isamp [3];
    logic               ov    [3];
    logic signed [15:0] os    [3];

    exp_t               sb    [3][$];
    logic signed [15:0] last  [3];
    int                 cyc;
    int                 n_checks;
    int                 n_fail;

    localparam int IMP   [11] = '{492, 1311, 2785, 4588, 7208, 7208, 4588, 2785, 1311, 492, 0};
    localparam int STEP  [10] = '{15, 55, 140, 280, 500, 720, 860, 945, 985, 1000};
    localparam int NEG   [10] = '{-492, -1803, -4588, -9176, -16384, -23592, -28180, -30965, -32276, -32768};
    localparam int SATN  [10] = '{32767, 32767, 32767, 32767, -5, -32768, -32768, -32768, -32768, -32768};
    localparam int RIN   [4]  = '{1, -1, 3, -3};
    localparam int ROUT  [4]  = '{1, 0, 2, -1};

    fir u_def (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (iv[0]),
        .in_sample  (isamp[0]),
        .out_valid  (ov[0]),
        .out_sample (os[0])
    );

    fir #(
        .TAPS     (10),
        .MULTBITS (32),
        .COEFF    ('{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767,
                     16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767})
    ) u_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (iv[1]),
        .in_sample  (isamp[1]),
        .out_valid  (ov[1]),
        .out_sample (os[1])
    );

    fir #(
        .TAPS     (10),
        .MULTBITS (32),
        .COEFF    ('{16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
                     16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0})
    ) u_rnd (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (iv[2]),
        .in_sample  (isamp[2]),
        .out_valid  (ov[2]),
        .out_sample (os[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops an expectation on every out_valid pulse, checks the
    // value and the cycle it appears in; between pulses checks the hold.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                n_checks++;
                if (ov[d] !== 1'b0 || os[d] !== 16'sd0) begin
                    n_fail++;
                    $display("FAIL in_reset dut%0d: got valid=%0b sample=%0d, expected valid=0 sample=0",
                             d, ov[d], os[d]);
                end
                sb[d].delete();
                last[d] = '0;
            end else if (ov[d] === 1'b1) begin
                n_checks++;
                if (sb[d].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out dut%0d cyc%0d: got pulse with sample=%0d, expected no pulse",
                             d, cyc, os[d]);
                end else begin
                    exp_t e;
                    e = sb[d].pop_front();
                    if (os[d] !== e.val || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL output dut%0d: got sample=%0d at cyc%0d, expected sample=%0d at cyc%0d",
                                 d, os[d], cyc, e.val, e.cyc);
                    end
                    last[d] = e.val;
                end
            end else begin
                n_checks++;
                if (os[d] !== last[d]) begin
                    n_fail++;
                    $display("FAIL hold dut%0d cyc%0d: got sample=%0d, expected held %0d",
                             d, cyc, os[d], last[d]);
                end
            end
        end
    end

    task automatic send(input int d, input bit v, input int s, input int e);
        exp_t it;
        @(negedge clk);
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        iv[d]    = v;
        isamp[d] = 16'(s);
        if (v) begin
            it.val = 16'(e);
            it.cyc = cyc + 2;
            sb[d].push_back(it);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        end
    endtask

    // Asserts reset 2 ns after the current negedge, checks that outputs clear
    // immediately, then releases it mid-cycle two negedges later.
    task automatic apply_reset();
        #2;
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (ov[d] !== 1'b0 || os[d] !== 16'sd0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got valid=%0b sample=%0d, expected valid=0 sample=0",
                         d, ov[d], os[d]);
            end
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k]    = 1'b0;
            isamp[k] = '0;
            last[k]  = '0;
        end
        #1 rst = 1'b0;
        @(negedge clk);
        apply_reset();

        // Impulse response with continuous valid.
        send(0, 1, 32767, IMP[0]);
        for (int k = 1; k < 11; k++) send(0, 1, 0, IMP[k]);

        // Step of 1000.
        for (int k = 0; k < 20; k++) send(0, 1, 1000, (k < 10) ? STEP[k] : 1000);

        // Mid-stream reset: first -32768 output emerges, the rest are discarded.
        send(0, 1, -32768, 493);
        send(0, 1, -32768, -858);
        send(0, 1, -32768, -3728);
        apply_reset();

        // Step of -32768 from a cleared delay line.
        for (int k = 0; k < 20; k++) send(0, 1, -32768, (k < 10) ? NEG[k] : -32768);

        @(negedge clk);
        apply_reset();

        // Impulse with in_valid gaps; garbage on in_sample while invalid.
        send(0, 1, 32767, IMP[0]);
        for (int k = 1; k < 11; k++) begin
            send(0, 0, 12345, 0);
            send(0, 1, 0, IMP[k]);
        end
        idle(4);

        // Rounding: one 0.5 tap.
        for (int k = 0; k < 4; k++) begin
            send(2, 1, RIN[k], ROUT[k]);
            send(2, 0, -7, 0);
        end
        idle(4);

        // Saturation: all-32767 coefficients.
        for (int k = 0; k < 10; k++) send(1, 1, 32767, (k == 0) ? 32766 : 32767);
        for (int k = 0; k < 10; k++) send(1, 1, -32768, SATN[k]);

        idle(6);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (sb[d].size() != 0) begin
                n_fail++;
                $display("FAIL drain dut%0d: got %0d outstanding results, expected 0", d, sb[d].size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir.md
Name: fir

Overview:
- Direct-form, fully pipelined FIR filter for a 16-bit signed sample stream.
- Accepts one sample per clock when in_valid is high; emits one filtered sample per accepted input after a fixed 2-cycle latency.
- Sits between the sample source (ADC or front-end) and downstream DSP. Output is Q1.15 scaled, rounded and saturated back to 16 bits.

Parameters:
- TAPS, 10: number of filter taps; legal range 2..64.
- MULTBITS, 32: width of each registered product; must be >= 32 (16x16 signed). Products are sign-extended to MULTBITS.
- COEFF, fir_pkg::DEFAULT_COEFF: array [TAPS] of signed 16-bit Q1.15 coefficients.
  - COEFF[0] applies to the newest sample.
  - Default for TAPS=10 (symmetric low-pass, unity DC gain, sum = 32768): 492, 1311, 2785, 4588, 7208, 7208, 4588, 2785, 1311, 492.

Ports:
- clk  in  1: single clock; all state updates on its rising edge.
- rst  in  1: reset, asynchronous, active-low.
- in_valid  in  1: in_sample is valid this cycle.
- in_sample  in  16: signed input sample, two's complement.
- out_valid  out  1: out_sample holds a new result this cycle (one-cycle pulse per result).
- out_sample  out  16: signed filtered output.

Behaviour:
- Reset (rst low, asynchronous):
  - Delay line, product registers and valid pipeline are cleared to 0.
  - out_sample = 0 and out_valid = 0.
  - Takes effect immediately, mid-stream included; in-flight samples are discarded.
- Delay line x[0..TAPS-1]: on an edge with in_valid=1, x[0] <= in_sample and x[i] <= x[i-1]. When in_valid=0 it holds.
- Stage 1: on the same edge with in_valid=1, register p[i] = in_sample*COEFF[0] for i=0, and x[i-1]*COEFF[i] for i>0. Each p[i] is a signed MULTBITS-wide value. v1 <= in_valid.
- Stage 2: on the next edge:
  - acc = signed sum of all p[i], width MULTBITS + ceil(log2 TAPS); no overflow is possible.
  - r = (acc + 2^14) >>> 15 (arithmetic shift, round half up).
  - Saturate r to [-32768, 32767].
  - out_sample <= saturated value; out_valid <= v1.
- Latency: an input accepted at edge k gives out_valid=1 with its result after edge k+2.
- Throughput: 1 sample/clock; back-to-back in_valid is fully supported.
- When in_valid=0: no shift occurs, a 0 propagates in the valid pipe, and out_sample holds its last value while out_valid=0.
- Gaps in in_valid do not insert zeros into the delay line (sample-indexed filter, not time-indexed).
- in_sample is ignored when in_valid=0. X on in_sample is tolerated while in_valid=0 or during reset.
- No backpressure; the downstream consumer must accept every out_valid pulse.

Decomposition:
- Package fir_pkg holds:
  - SAMPLE_W=16, COEFF_W=16, FRAC_BITS=15;
  - typedefs sample_t and coeff_t (logic signed [15:0]);
  - DEFAULT_COEFF;
  - function sat16 (round and saturate).
- One natural sub-module, fir_adder_tree: a parameterized combinational signed sum of TAPS MULTBITS-wide inputs. The fir module registers its output.

Test Plan:
- Reset: hold rst low for 2 cycles mid-stream -> out_sample=0 and out_valid=0 immediately; first post-reset output uses a cleared delay line.
- Impulse: one sample 32767 then 0s (in_valid=1 continuously) -> the 10 successive outputs, starting 2 cycles after the impulse, are exactly 492, 1311, 2785, 4588, 7208, 7208, 4588, 2785, 1311, 492, then 0.
- Step: constant 1000 for 20 samples -> outputs ramp monotonically and settle at exactly 1000 from the 10th output onward; constant -32768 settles at -32768.
- Valid gaps: impulse 32767, then in_valid toggled 1/0 with in_sample=0 when valid -> the same 10-value sequence appears, one value per valid input; out_valid pulses only 2 cycles after each valid input; out_sample holds between pulses.
- Saturation: COEFF overridden to all 32767 and constant input 32767 -> out_sample saturates to 32767; with constant input -32768 -> saturates to -32768.
- Rounding: COEFF[0]=16384 with all others 0, input 1 -> output 1 (0.5 rounds up); input -1 -> output 0.
